// File: rtl/test_status_monitor.sv
// Memory-mapped self-test monitor: result mailboxes, pass/fail/timeout FSM, status outputs.
// Optional cycle counter at BASE+4 enabled by defining TEST_MON_CYCLE_CNT_EN.
module test_status_monitor #(
   parameter logic [31:0] BASE_ADDR   = 32'h3FF0,
   parameter int unsigned NUM_CH      = 2,
   parameter logic [31:0] PASS_CODE   = 32'hAA55AA55,
   parameter logic [31:0] FAIL_CODE   = 32'hFFFFFFFF,
   parameter int unsigned TIMEOUT_CYC = 100000,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [31:0]     DataADDR,
   input  logic [31:0]     WriteData,
   input  logic [3:0]      mem_write_req,
   input  logic            mem_read_req,
   output logic            mon_hit,
   output logic [31:0]     mon_rdata,
   output logic            test_done,
   output logic            test_pass,
   output logic            test_fail,
   output logic            test_timeout,
   output logic [CH_W-1:0] fail_ch,
   output logic [31:0]     last_code
);

   typedef enum logic [3:0] {
      S_RUN  = 4'b0001,
      S_PASS = 4'b0010,
      S_FAIL = 4'b0100,
      S_TMO  = 4'b1000
   } state_t;

   localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
   localparam logic [29:0] END_W  = BASE_W + 30'(NUM_CH + 2);

   state_t            state_q, state_d;
   logic [31:0]       mbox_q [NUM_CH];
   logic [31:0]       mbox_d [NUM_CH];
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic              err_q, err_d;
   logic [31:0]       wd_q, wd_d;
   logic [CH_W-1:0]   fch_q, fch_d;
   logic [31:0]       last_q, last_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [29:0]       wa;
   logic [29:0]       off;
   logic              wr_full;
   logic              wr_part;
   logic              ctrl_clr;
   logic              mb_wr;
   logic [CH_W-1:0]   mb_idx;
   logic [31:0]       cyc_rd;
   logic [31:0]       status;

   // Byte offset bits play no part in decode
   logic unused_addr_lsb;
   assign unused_addr_lsb = &{1'b0, DataADDR[1:0]};

   assign wa       = DataADDR[31:2];
   assign off      = wa - BASE_W;
   assign mon_hit  = (wa >= BASE_W) && (wa < END_W);
   assign wr_full  = mon_hit && (mem_write_req == 4'b1111);
   assign wr_part  = mon_hit && (mem_write_req != 4'b0000)
                     && (mem_write_req != 4'b1111);
   assign ctrl_clr = wr_full && (off == 30'd0) && WriteData[0];

   always_comb begin
      mb_wr  = 1'b0;
      mb_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (off == 30'(i + 2)) begin
            mb_wr  = wr_full;
            mb_idx = CH_W'(i);
         end
      end
   end

`ifdef TEST_MON_CYCLE_CNT_EN
   logic [31:0] cyc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q <= '0;
      end else if (ctrl_clr) begin
         cyc_q <= '0;
      end else if (state_q == S_RUN && cyc_q != 32'hFFFFFFFF) begin
         cyc_q <= cyc_q + 32'd1;
      end
   end

   assign cyc_rd = cyc_q;
`else
   assign cyc_rd = 32'h0;
`endif

   assign status = {12'b0, err_q, 3'(fch_q), 8'(mask_q), 4'b0, state_q};

   always_comb begin
      state_d = state_q;
      mbox_d  = mbox_q;
      mask_d  = mask_q;
      err_d   = err_q;
      wd_d    = wd_q;
      fch_d   = fch_q;
      last_d  = last_q;
      if (ctrl_clr) begin
         state_d = S_RUN;
         for (int i = 0; i < NUM_CH; i++) mbox_d[i] = '0;
         mask_d  = '0;
         err_d   = 1'b0;
         wd_d    = '0;
         last_d  = '0;
      end else if (state_q == S_RUN) begin
         if (mb_wr) begin
            mbox_d[mb_idx] = WriteData;
            last_d = WriteData;
            wd_d   = '0;
            if (WriteData == FAIL_CODE) begin
               state_d = S_FAIL;
               fch_d   = mb_idx;
            end else if (WriteData == PASS_CODE) begin
               mask_d[mb_idx] = 1'b1;
               if (&mask_d) state_d = S_PASS;
            end else begin
               mask_d[mb_idx] = 1'b0;
            end
         end else begin
            // A same-cycle mailbox write takes the other branch, so it beats expiry
            if (TIMEOUT_CYC != 0 && wd_q == 32'(TIMEOUT_CYC - 1))
               state_d = S_TMO;
            if (wd_q != 32'hFFFFFFFF) wd_d = wd_q + 32'd1;
         end
      end
      if (wr_part) err_d = 1'b1;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (mem_read_req && mon_hit) begin
         rdata_d = '0;
         if (off == 30'd0) rdata_d = status;
         if (off == 30'd1) rdata_d = cyc_rd;
         for (int i = 0; i < NUM_CH; i++)
            if (off == 30'(i + 2)) rdata_d = mbox_q[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_RUN;
         for (int i = 0; i < NUM_CH; i++) mbox_q[i] <= '0;
         mask_q  <= '0;
         err_q   <= 1'b0;
         wd_q    <= '0;
         fch_q   <= '0;
         last_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         mbox_q  <= mbox_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
         fch_q   <= fch_d;
         last_q  <= last_d;
         rdata_q <= rdata_d;
      end
   end

   assign mon_rdata    = rdata_q;
   assign test_done    = (state_q != S_RUN);
   assign test_pass    = (state_q == S_PASS);
   assign test_fail    = (state_q == S_FAIL);
   assign test_timeout = (state_q == S_TMO);
   assign fail_ch      = fch_q;
   assign last_code    = last_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor (TIMEOUT_CYC=16, two channels).
module tb_test_status_monitor;

   localparam logic [31:0] PASS_C = 32'hAA55AA55;
   localparam logic [31:0] FAIL_C = 32'hFFFFFFFF;
   localparam logic [31:0] A_ST   = 32'h3FF0;
   localparam logic [31:0] A_CY   = 32'h3FF4;
   localparam logic [31:0] A_M0   = 32'h3FF8;
   localparam logic [31:0] A_M1   = 32'h3FFC;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] DataADDR = '0;
   logic [31:0] WriteData = '0;
   logic [3:0]  mem_write_req = '0;
   logic        mem_read_req = 1'b0;
   logic        mon_hit;
   logic [31:0] mon_rdata;
   logic        test_done, test_pass, test_fail, test_timeout;
   logic [0:0]  fail_ch;
   logic [31:0] last_code;

   int checks = 0;
   int passed = 0;

   test_status_monitor #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset_n(reset_n), .DataADDR(DataADDR),
      .WriteData(WriteData), .mem_write_req(mem_write_req),
      .mem_read_req(mem_read_req), .mon_hit(mon_hit),
      .mon_rdata(mon_rdata), .test_done(test_done),
      .test_pass(test_pass), .test_fail(test_fail),
      .test_timeout(test_timeout), .fail_ch(fail_ch),
      .last_code(last_code)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog sim time exceeded");
      $fatal(1);
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      DataADDR = a; WriteData = d; mem_write_req = s;
      @(negedge clk);
      mem_write_req = 4'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      DataADDR = a; mem_read_req = 1'b1;
      @(negedge clk);
      mem_read_req = 1'b0;
      d = mon_rdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({test_done, test_pass, test_fail, test_timeout} !== 4'b0)
         $display("FAIL rst_status got %b exp 0000",
                  {test_done, test_pass, test_fail, test_timeout});
      else passed++;
      checks++;
      if (mon_rdata !== 32'h0 || last_code !== 32'h0 || fail_ch !== 1'b0)
         $display("FAIL rst_regs got %h %h %b exp 0", mon_rdata, last_code, fail_ch);
      else passed++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_decode();
      logic [31:0] a [4];
      logic        e [4];
      a = '{32'h3FF0, 32'h3FFF, 32'h3FEF, 32'h4000};
      e = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         DataADDR = a[i];
         #1;
         checks++;
         if (mon_hit !== e[i])
            $display("FAIL hit_%h got %b exp %b", a[i], mon_hit, e[i]);
         else passed++;
      end
      @(negedge clk);
   endtask

   task automatic test_pass_seq();
      logic [31:0] d;
      do_reset();
      wr(A_M0, PASS_C, 4'hF);
      checks++;
      if (test_pass !== 1'b0) $display("FAIL pass_early got %b exp 0", test_pass);
      else passed++;
      wr(A_M1, PASS_C, 4'hF);
      checks++;
      if (test_pass !== 1'b1 || test_done !== 1'b1)
         $display("FAIL pass_out got %b%b exp 11", test_pass, test_done);
      else passed++;
      rd(A_ST, d);
      checks++;
      if (d !== 32'h0000_0302) $display("FAIL pass_status got %h exp 00000302", d);
      else passed++;
      wr(A_M0, FAIL_C, 4'hF);
      checks++;
      if (test_pass !== 1'b1 || test_fail !== 1'b0)
         $display("FAIL term_ignore got %b%b exp 10", test_pass, test_fail);
      else passed++;
      rd(A_M0, d);
      checks++;
      if (d !== PASS_C || last_code !== PASS_C)
         $display("FAIL term_mbox got %h %h exp %h", d, last_code, PASS_C);
      else passed++;
   endtask

   task automatic test_fail_seq();
      logic [31:0] d;
      do_reset();
      wr(A_M0, 32'd7, 4'hF);
      wr(A_M1, FAIL_C, 4'hF);
      checks++;
      if (test_fail !== 1'b1 || fail_ch !== 1'b1 || last_code !== FAIL_C)
         $display("FAIL fail_out got %b %b %h exp 1 1 ffffffff",
                  test_fail, fail_ch, last_code);
      else passed++;
      rd(A_M0, d);
      checks++;
      if (d !== 32'd7) $display("FAIL fail_mbox0 got %h exp 7", d);
      else passed++;
      rd(A_ST, d);
      checks++;
      if (d !== 32'h0001_0004) $display("FAIL fail_status got %h exp 00010004", d);
      else passed++;
      wr(A_ST, 32'h1, 4'hF);
      checks++;
      if (test_fail !== 1'b0 || test_done !== 1'b0)
         $display("FAIL fail_clear got %b%b exp 00", test_fail, test_done);
      else passed++;
   endtask

   task automatic test_timeout_seq();
      do_reset();
      idle(15);
      checks++;
      if (test_timeout !== 1'b0) $display("FAIL tmo_early got %b exp 0", test_timeout);
      else passed++;
      idle(1);
      checks++;
      if (test_timeout !== 1'b1 || test_done !== 1'b1)
         $display("FAIL tmo_fire got %b%b exp 11", test_timeout, test_done);
      else passed++;
      do_reset();
      idle(15);
      wr(A_M0, 32'd5, 4'hF);
      checks++;
      if (test_timeout !== 1'b0) $display("FAIL tmo_write_wins got %b exp 0", test_timeout);
      else passed++;
      idle(15);
      checks++;
      if (test_timeout !== 1'b0) $display("FAIL tmo_rearm_early got %b exp 0", test_timeout);
      else passed++;
      idle(1);
      checks++;
      if (test_timeout !== 1'b1) $display("FAIL tmo_rearm got %b exp 1", test_timeout);
      else passed++;
   endtask

   task automatic test_err_ctrl();
      logic [31:0] d;
      do_reset();
      wr(A_M0, PASS_C, 4'hF);
      wr(A_M1, 32'h1234, 4'b0011);
      rd(A_M1, d);
      checks++;
      if (d !== 32'h0) $display("FAIL part_mbox got %h exp 0", d);
      else passed++;
      wr(A_ST, 32'h0, 4'hF);
      rd(A_ST, d);
      checks++;
      if (d !== 32'h0008_0101) $display("FAIL err_status got %h exp 00080101", d);
      else passed++;
      wr(A_ST, 32'h1, 4'hF);
      rd(A_ST, d);
      checks++;
      if (d !== 32'h0000_0001) $display("FAIL ctrl_status got %h exp 00000001", d);
      else passed++;
      rd(A_M0, d);
      checks++;
      if (d !== 32'h0 || last_code !== 32'h0)
         $display("FAIL ctrl_mbox got %h %h exp 0 0", d, last_code);
      else passed++;
      rd(32'h4000, d);
      checks++;
      if (d !== 32'h0) $display("FAIL miss_hold got %h exp 0", d);
      else passed++;
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      do_reset();
      wr(A_M0, 32'h55, 4'hF);
      rd(A_M0, d);
      checks++;
      if (d !== 32'h55) $display("FAIL ar_pre got %h exp 55", d);
      else passed++;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (mon_rdata !== 32'h0 || last_code !== 32'h0 || test_done !== 1'b0)
         $display("FAIL ar_clear got %h %h %b exp 0", mon_rdata, last_code, test_done);
      else passed++;
      @(negedge clk);
      reset_n = 1'b1;
      rd(A_M0, d);
      checks++;
      if (d !== 32'h0) $display("FAIL ar_mbox got %h exp 0", d);
      else passed++;
   endtask

   task automatic test_cycles();
      logic [31:0] d;
      logic [31:0] exp_c;
`ifdef TEST_MON_CYCLE_CNT_EN
      exp_c = 32'd50;
`else
      exp_c = 32'd0;
`endif
      do_reset();
      for (int i = 0; i < 48; i++) wr(A_M1, 32'h100 + i, 4'hF);
      wr(A_M0, PASS_C, 4'hF);
      wr(A_M1, PASS_C, 4'hF);
      checks++;
      if (test_pass !== 1'b1) $display("FAIL cyc_pass got %b exp 1", test_pass);
      else passed++;
      wr(A_CY, 32'hDEAD, 4'hF);
      rd(A_CY, d);
      checks++;
      if (d !== exp_c) $display("FAIL cyc_read got %0d exp %0d", d, exp_c);
      else passed++;
      idle(5);
      rd(A_CY, d);
      checks++;
      if (d !== exp_c) $display("FAIL cyc_stable got %0d exp %0d", d, exp_c);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_pass_seq();
      test_fail_seq();
      test_timeout_seq();
      test_err_ctrl();
      test_async_reset();
      test_cycles();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
